sbox_arbiter: RTL and testbench

- Shares one S-box lookup port (8-bit address out, 8-bit substituted byte back, two-phase handshake) among NREQ requesters, e.g. the SubBytes sequencer and the key-expansion unit.
- Round-robin arbitration with one outstanding S-box transaction at a time.
- Per-requester response pulse, plus a timeout that releases a stuck transaction.

---
 rtl/sbox_arbiter.sv | 154 +++++++++++++++
 tb/tb_sbox_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_arbiter.sv
// rtl/sbox_arbiter.sv - round-robin arbiter sharing one S-box lookup port among NREQ requesters
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_addr  per-requester pending flag and lookup byte (byte i = bits 8i+7:8i)
//   resp_valid          one-cycle pulse on the bit of the requester being answered
//   resp_data/resp_err  substituted byte (0x00 on timeout) and timeout flag, held until next response
//   sbox_rqst_addr      address driven to the S-box, stable while sbox_addr_valid is high
//   sbox_addr_valid     address phase active; sbox_addr_ack closes it
//   sbox_read_data      S-box byte, qualified by sbox_data_valid
//   busy                high whenever a transaction is in flight
//   grant_idx           index of the current or most recently granted requester
module sbox_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]     resp_valid,
    output logic [7:0]          resp_data,
    output logic                resp_err,
    output logic [7:0]          sbox_rqst_addr,
    output logic                sbox_addr_valid,
    input  logic                sbox_addr_ack,
    input  logic [7:0]          sbox_read_data,
    input  logic                sbox_data_valid,
    output logic                busy,
    output logic [IW-1:0]       grant_idx
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   last_grant;
    logic [CW-1:0]   cnt;
    logic [7:0]      addr_q;
    logic [7:0]      data_q;
    logic            err_q;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   pick_try;
    logic [7:0]      pick_addr;
    logic            timeout_hit;
    int              pick_pos;

    // Round-robin search: start just above the last served requester and wrap,
    // so the requester served most recently is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_try   = '0;
        pick_pos   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            pick_pos = (int'(last_grant) + k) % NREQ;
            pick_try = IW'(pick_pos);
            if (!pick_found && req_valid[pick_try]) begin
                pick_found = 1'b1;
                pick_idx   = pick_try;
            end
        end
    end

    always_comb begin
        pick_addr = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_addr = req_addr[8*i +: 8];
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_found) next_state = ISSUE;
            ISSUE:   if (sbox_addr_ack) next_state = WAIT;
            // Data takes priority when it arrives on the timeout cycle.
            WAIT:    if (sbox_data_valid || timeout_hit) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_idx  <= '0;
            last_grant <= IW'(NREQ - 1);
            cnt        <= '0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx <= pick_idx;
                        addr_q    <= pick_addr;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (sbox_data_valid) begin
                        data_q <= sbox_read_data;
                        err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        data_q <= 8'h00;
                        err_q  <= 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= grant_idx;
                    cnt        <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = (state == RESP) && (grant_idx == IW'(i));
        end
    end

    assign resp_data       = data_q;
    assign resp_err        = err_q;
    assign sbox_rqst_addr  = addr_q;
    assign sbox_addr_valid = (state == ISSUE);
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_sbox_arbiter.sv
// tb/tb_sbox_arbiter.sv - self-checking bench for sbox_arbiter
module tb_sbox_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 64;
    localparam int IW      = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_addr;
    logic [NREQ-1:0]     resp_valid;
    logic [7:0]          resp_data;
    logic                resp_err;
    logic [7:0]          sbox_rqst_addr;
    logic                sbox_addr_valid;
    logic                sbox_addr_ack;
    logic [7:0]          sbox_read_data;
    logic                sbox_data_valid;
    logic                busy;
    logic [IW-1:0]       grant_idx;

    always #5 clk = ~clk;

    sbox_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .sbox_rqst_addr(sbox_rqst_addr), .sbox_addr_valid(sbox_addr_valid),
        .sbox_addr_ack(sbox_addr_ack), .sbox_read_data(sbox_read_data),
        .sbox_data_valid(sbox_data_valid), .busy(busy), .grant_idx(grant_idx)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sbox_fn(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h63;
            8'h01:   return 8'h7C;
            8'h53:   return 8'hED;
            8'hFF:   return 8'h16;
            default: return {a[4:0], a[7:5]} ^ 8'h5A;
        endcase
    endfunction

    // Round-robin rule: first pending requester above the last served one, with wrap.
    function automatic int rr(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Configuration shared with the S-box model (written by main only).
    int  cfg_ack_dly  = 0;
    int  cfg_data_dly = 0;
    bit  cfg_data_en  = 1'b1;
    bit  rand_mode    = 1'b0;
    bit  inject_on    = 1'b0;

    // S-box model state (written by the S-box model only).
    int          av = 0;
    int          w = 0;
    int          ack_dly = 0;
    int          data_dly = 0;
    bit          data_en = 1'b1;
    bit          in_wait = 1'b0;
    logic [7:0]  cur_addr = 8'h00;
    int          last_av_len = 0;
    bit          cur_exp_err = 1'b0;

    // Monitor state (written by the monitor only).
    int          cyc = 0;
    int          model_last = NREQ - 1;
    bit          prev_av = 1'b0;
    bit          active = 1'b0;
    int          g_cur = 0;
    logic [7:0]  a_cur = 8'h00;
    int          last_resp_cyc = -1;
    int          last_resp_idx = -1;
    int          r_idx[$];
    int          r_data[$];
    int          r_err[$];
    int          r_cyc[$];
    int          g_q[$];

    // S-box peripheral model: acks after ack_dly extra cycles, returns data after data_dly.
    initial begin
        sbox_addr_ack   = 1'b0;
        sbox_data_valid = 1'b0;
        sbox_read_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sbox_addr_ack   = 1'b0;
                sbox_data_valid = 1'b0;
                in_wait = 1'b0;
                av = 0;
                w = 0;
            end else begin
                if (sbox_addr_ack) begin
                    sbox_addr_ack = 1'b0;
                    last_av_len = av;
                    in_wait = 1'b1;
                    w = 0;
                    data_dly = rand_mode ? $urandom_range(0, 4) : cfg_data_dly;
                    data_en  = rand_mode ? ($urandom_range(0, 9) != 0) : cfg_data_en;
                    cur_exp_err = !data_en;
                    check("addr_released", 32'(sbox_addr_valid), 32'd0);
                end
                if (!in_wait) sbox_data_valid = 1'b0;
                if (in_wait) begin
                    if (sbox_data_valid) begin
                        sbox_data_valid = 1'b0;
                        in_wait = 1'b0;
                        check("resp_after_data", 32'(|resp_valid), 32'd1);
                    end else if (|resp_valid) begin
                        in_wait = 1'b0;
                        check("timeout_len", 32'(w), 32'(TIMEOUT));
                    end else begin
                        sbox_data_valid = data_en && (w == data_dly);
                        sbox_read_data  = sbox_data_valid ? sbox_fn(cur_addr) : 8'hA5;
                        w++;
                    end
                end else if (sbox_addr_valid) begin
                    if (av == 0) begin
                        cur_addr = sbox_rqst_addr;
                        ack_dly = rand_mode ? $urandom_range(0, 3) : cfg_ack_dly;
                    end else if (sbox_rqst_addr !== cur_addr) begin
                        check("addr_stable", 32'(sbox_rqst_addr), 32'(cur_addr));
                    end
                    sbox_addr_ack = (av == ack_dly);
                    av++;
                end else begin
                    av = 0;
                end
            end
            if (inject_on) begin
                sbox_data_valid = 1'b1;
                sbox_read_data  = 8'hAA;
            end
        end
    end

    // Monitor and reference model: checks each grant and each response.
    initial begin
        int exp_g;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                model_last = NREQ - 1;
                prev_av = 1'b0;
                active = 1'b0;
            end else begin
                if (sbox_addr_valid && !prev_av) begin
                    exp_g = rr(req_valid, model_last);
                    check("grant_idx", 32'(grant_idx), 32'(exp_g));
                    g_cur = exp_g;
                    a_cur = (exp_g >= 0) ? req_addr[8*exp_g +: 8] : 8'h00;
                    check("grant_addr", 32'(sbox_rqst_addr), 32'(a_cur));
                    active = 1'b1;
                    g_q.push_back(int'(grant_idx));
                end
                if (|resp_valid) begin
                    check("resp_onehot", 32'($countones(resp_valid)), 32'd1);
                    check("resp_active", 32'(active), 32'd1);
                    check("resp_vec", 32'(resp_valid), 32'(1 << g_cur));
                    check("resp_err", 32'(resp_err), 32'(cur_exp_err));
                    check("resp_data", 32'(resp_data), cur_exp_err ? 32'd0 : 32'(sbox_fn(a_cur)));
                    model_last = g_cur;
                    active = 1'b0;
                    last_resp_cyc = cyc;
                    last_resp_idx = g_cur;
                    r_idx.push_back(g_cur);
                    r_data.push_back(int'(resp_data));
                    r_err.push_back(int'(resp_err));
                    r_cyc.push_back(cyc);
                end
                prev_av = sbox_addr_valid;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag, input int n, input int budget);
        int b = 0;
        while (r_idx.size() < n && b < budget) begin
            tick();
            b++;
        end
        check(tag, 32'(r_idx.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int c0, base, gbase, busy_low, b, n1;
        rst = 1'b0;
        req_valid = '0;
        req_addr = '0;
        tick();
        tick();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_addr", 32'(sbox_rqst_addr), 32'd0);
        check("rst_addr_valid", 32'(sbox_addr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        rst = 1'b1;
        tick();

        // 1: single lookup, minimum latency
        base = r_idx.size();
        req_addr[7:0] = 8'h53;
        req_valid = 3'b001;
        c0 = cyc;
        wait_resp("t1_wait", base + 1, 20);
        req_valid = '0;
        if (r_idx.size() > base) begin
            check("t1_latency", 32'(r_cyc[base] - c0), 32'd3);
            check("t1_idx", 32'(r_idx[base]), 32'd0);
            check("t1_data", 32'(r_data[base]), 32'hED);
            check("t1_err", 32'(r_err[base]), 32'd0);
        end
        check("t1_av_len", 32'(last_av_len), 32'd1);
        tick();
        check("t1_idle", 32'(busy), 32'd0);

        // 2: simultaneous requests rotate 0,1,0,1
        do_reset();
        base = r_idx.size();
        req_addr[7:0] = 8'h00;
        req_addr[15:8] = 8'h01;
        req_valid = 3'b011;
        wait_resp("t2_wait", base + 4, 40);
        req_valid = '0;
        if (r_idx.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) check("t2_order", 32'(r_idx[base + k]), 32'(k % 2));
            check("t2_data0", 32'(r_data[base]), 32'h63);
            check("t2_data1", 32'(r_data[base + 1]), 32'h7C);
        end

        // 3: slow S-box
        do_reset();
        base = r_idx.size();
        cfg_ack_dly = 5;
        cfg_data_dly = 7;
        req_addr[7:0] = 8'hFF;
        req_valid = 3'b001;
        busy_low = 0;
        b = 0;
        while (r_idx.size() == base && b < 60) begin
            tick();
            b++;
            if (!busy) busy_low++;
        end
        req_valid = '0;
        check("t3_done", 32'(r_idx.size()), 32'(base + 1));
        check("t3_busy", 32'(busy_low), 32'd0);
        check("t3_av_len", 32'(last_av_len), 32'd6);
        if (r_idx.size() > base) check("t3_data", 32'(r_data[base]), 32'h16);
        cfg_ack_dly = 0;
        cfg_data_dly = 0;

        // 4: timeout, then a normal lookup
        do_reset();
        base = r_idx.size();
        cfg_data_en = 1'b0;
        req_addr[7:0] = 8'h10;
        req_valid = 3'b001;
        wait_resp("t4_wait", base + 1, 100);
        cfg_data_en = 1'b1;
        req_addr[7:0] = 8'h20;
        wait_resp("t4_wait2", base + 2, 20);
        req_valid = '0;
        if (r_idx.size() >= base + 2) begin
            check("t4_err", 32'(r_err[base]), 32'd1);
            check("t4_data", 32'(r_data[base]), 32'd0);
            check("t4_err2", 32'(r_err[base + 1]), 32'd0);
            check("t4_data2", 32'(r_data[base + 1]), 32'(sbox_fn(8'h20)));
        end

        // 5: reset during WAIT
        do_reset();
        base = r_idx.size();
        req_addr[7:0] = 8'h30;
        req_valid = 3'b001;
        wait_resp("t5_first", base + 1, 20);
        req_valid = '0;
        tick();
        cfg_data_en = 1'b0;
        req_addr[7:0] = 8'h31;
        req_valid = 3'b001;
        repeat (5) tick();
        rst = 1'b0;
        req_valid = '0;
        #1;
        check("t5_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_resp_data", 32'(resp_data), 32'd0);
        check("t5_resp_err", 32'(resp_err), 32'd0);
        check("t5_addr", 32'(sbox_rqst_addr), 32'd0);
        check("t5_addr_valid", 32'(sbox_addr_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        cfg_data_en = 1'b1;
        n1 = r_idx.size();
        inject_on = 1'b1;
        tick();
        tick();
        inject_on = 1'b0;
        repeat (6) tick();
        check("t5_no_resp", 32'(r_idx.size()), 32'(n1));
        check("t5_idle", 32'(busy), 32'd0);
        req_addr[7:0] = 8'h32;
        req_addr[15:8] = 8'h33;
        req_valid = 3'b011;
        wait_resp("t5_after", n1 + 1, 20);
        req_valid = '0;
        if (r_idx.size() > n1) check("t5_grant0", 32'(r_idx[n1]), 32'd0);

        // 6: withdrawn request
        do_reset();
        base = r_idx.size();
        gbase = g_q.size();
        cfg_data_dly = 3;
        req_addr[7:0] = 8'h40;
        req_addr[15:8] = 8'h41;
        req_valid = 3'b001;
        tick();
        tick();
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        wait_resp("t6_wait", base + 1, 20);
        req_valid = '0;
        repeat (10) tick();
        cfg_data_dly = 0;
        n1 = 0;
        for (int k = gbase; k < g_q.size(); k++) if (g_q[k] == 1) n1++;
        check("t6_no_grant1", 32'(n1), 32'd0);
        check("t6_resp_count", 32'(r_idx.size()), 32'(base + 1));

        // Randomized traffic checked by the monitor model.
        do_reset();
        rand_mode = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    if (last_resp_cyc == cyc && last_resp_idx == i) begin
                        if ($urandom_range(0, 1) == 1) req_addr[8*i +: 8] = 8'($urandom);
                        else req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req_addr[8*i +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
        end
        b = 0;
        while (req_valid != '0 && b < 3000) begin
            tick();
            b++;
            if (last_resp_cyc == cyc && last_resp_idx >= 0) req_valid[last_resp_idx] = 1'b0;
        end
        check("rand_drained", 32'(req_valid), 32'd0);
        rand_mode = 1'b0;
        repeat (4) tick();

        // Full saturation: grants rotate through every requester.
        do_reset();
        base = r_idx.size();
        req_addr = {8'h12, 8'h34, 8'h56};
        req_valid = '1;
        wait_resp("sat_wait", base + 2 * NREQ, 80);
        req_valid = '0;
        if (r_idx.size() >= base + 2 * NREQ) begin
            for (int k = 0; k < 2 * NREQ; k++) check("sat_order", 32'(r_idx[base + k]), 32'(k % NREQ));
        end
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
